// File: rtl/lbp_stream_engine.sv
// Streaming 3x3 LBP engine. It reads a gray image once in raster order and
// writes one 8-bit code per centre pixel. Two line buffers hold the previous
// two rows, so the engine sustains one pixel per cycle.
//
// Handshake: there is no backpressure on either side. gray_req=1 means
// gray_addr is valid and gray_data must carry that pixel in the same cycle.
// lbp_valid=1 means lbp_addr/lbp_data form a write that the result RAM
// must accept in that cycle.
module lbp_stream_engine #(
  parameter int IMG_W  = 128,
  parameter int IMG_H  = 128,
  parameter int DW     = 8,
  parameter int BORDER = 0,
  parameter int CMP_GE = 1,
  localparam int AW    = $clog2(IMG_W*IMG_H)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          gray_ready,
  output logic          gray_req,
  output logic [AW-1:0] gray_addr,
  input  logic [DW-1:0] gray_data,
  output logic          lbp_valid,
  output logic [AW-1:0] lbp_addr,
  output logic [7:0]    lbp_data,
  output logic          finish,
  output logic [1:0]    dbg_state
);

  localparam int NPIX = IMG_W*IMG_H;
  // Step counter runs past the last read by IMG_W+1 when border zeros are written.
  localparam int KW   = $clog2(NPIX+IMG_W+1);
  localparam int CW   = $clog2(IMG_W);
  // The row of k reaches IMG_H+1 on the final flush step.
  localparam int RW   = $clog2(IMG_H+2);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [KW-1:0] k;
  logic [CW-1:0] kc;
  logic [RW-1:0] kr;

  logic [DW-1:0] lb0 [IMG_W];
  logic [DW-1:0] lb1 [IMG_W];
  // Middle and right columns of the current window: [0]=middle, [1]=right.
  logic [DW-1:0] wt [2];
  logic [DW-1:0] wm [2];
  logic [DW-1:0] wb [2];

  logic          step;
  logic          last_read;
  logic          last_flush;
  logic [DW-1:0] top_in, mid_in, bot_in;
  logic [7:0]    code;
  logic          interior;
  logic          j_valid;
  logic          emit;

  function automatic logic hit(input logic [DW-1:0] n, input logic [DW-1:0] c);
    return (CMP_GE != 0) ? (n >= c) : (n > c);
  endfunction

  assign step       = (state == S_READ) || (state == S_FLUSH);
  assign last_read  = (state == S_READ)  && (k == KW'(NPIX-1));
  assign last_flush = (state == S_FLUSH) && (k == KW'(NPIX+IMG_W));

  assign top_in = lb0[kc];
  assign mid_in = lb1[kc];
  assign bot_in = gray_data;

  // A centre whose column is 0 or IMG_W-1 maps to kc==0 or kc==1, so an
  // interior centre never straddles a row boundary and sits at (kr-1, kc-1).
  assign interior = (state == S_READ) && (kc >= CW'(2)) &&
                    (kr >= RW'(2)) && (kr <= RW'(IMG_H-1));
  // Centre index j = k-IMG_W-1 is non-negative.
  assign j_valid  = (kr >= RW'(2)) || ((kr == RW'(1)) && (kc != '0));
  assign emit     = step && ((BORDER != 0) ? j_valid : interior);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (gray_ready) state_nxt = S_READ;
      S_READ:  if (last_read)  state_nxt = (BORDER != 0) ? S_FLUSH : S_DONE;
      S_FLUSH: if (last_flush) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    gray_req  = (state == S_READ);
    gray_addr = (state == S_READ) ? k[AW-1:0] : '0;
    finish    = (state == S_DONE);
    dbg_state = state;
  end

  // Step counter with its row/column split, cleared outside a frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      k  <= '0;
      kc <= '0;
      kr <= '0;
    end else if (step) begin
      k <= k + KW'(1);
      if (kc == CW'(IMG_W-1)) begin
        kc <= '0;
        kr <= kr + RW'(1);
      end else begin
        kc <= kc + CW'(1);
      end
    end else begin
      k  <= '0;
      kc <= '0;
      kr <= '0;
    end
  end

  // Line buffers and window shift; contents need no reset.
  always_ff @(posedge clk) begin
    if (state == S_READ) begin
      lb0[kc] <= lb1[kc];
      lb1[kc] <= gray_data;
      wt[0]   <= wt[1];
      wt[1]   <= top_in;
      wm[0]   <= wm[1];
      wm[1]   <= mid_in;
      wb[0]   <= wb[1];
      wb[1]   <= bot_in;
    end
  end

  // Code of the window after this step's shift; centre is the old right-middle pixel.
  always_comb begin
    code = {hit(bot_in, wm[1]), hit(wb[1], wm[1]), hit(wb[0], wm[1]),
            hit(mid_in, wm[1]), hit(wm[0], wm[1]),
            hit(top_in, wm[1]), hit(wt[1], wm[1]), hit(wt[0], wm[1])};
  end

  // Registered write port; address and data hold between writes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lbp_valid <= 1'b0;
      lbp_addr  <= '0;
      lbp_data  <= '0;
    end else begin
      lbp_valid <= emit;
      if (emit) begin
        lbp_addr <= AW'(k - KW'(IMG_W+1));
        lbp_data <= interior ? code : 8'h00;
      end
    end
  end

endmodule

// File: tb/tb_lbp_stream_engine.sv
// Bench for lbp_stream_engine: three instances (8x6 SKIP/GE, 4x4 ZERO/GE,
// 5x5 SKIP/GT) share one clock and reset; one instance is observed at a time.
module tb_lbp_stream_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic rdy_a, rdy_b, rdy_c;

  logic       req_a, lv_a, fin_a;
  logic [5:0] ga_a, la_a;
  logic [7:0] gd_a, ld_a;
  logic [1:0] st_a;
  logic       req_b, lv_b, fin_b;
  logic [3:0] ga_b, la_b;
  logic [7:0] gd_b, ld_b;
  logic [1:0] st_b;
  logic       req_c, lv_c, fin_c;
  logic [4:0] ga_c, la_c;
  logic [7:0] gd_c, ld_c;
  logic [1:0] st_c;

  logic [7:0] img_a [48];
  logic [7:0] img_b [16];
  logic [7:0] img_c [25];

  assign gd_a = img_a[ga_a];
  assign gd_b = img_b[ga_b];
  assign gd_c = img_c[ga_c];

  lbp_stream_engine #(.IMG_W(8), .IMG_H(6), .DW(8), .BORDER(0), .CMP_GE(1)) dut_a (
    .clk(clk), .reset(reset), .gray_ready(rdy_a), .gray_req(req_a), .gray_addr(ga_a),
    .gray_data(gd_a), .lbp_valid(lv_a), .lbp_addr(la_a), .lbp_data(ld_a),
    .finish(fin_a), .dbg_state(st_a));

  lbp_stream_engine #(.IMG_W(4), .IMG_H(4), .DW(8), .BORDER(1), .CMP_GE(1)) dut_b (
    .clk(clk), .reset(reset), .gray_ready(rdy_b), .gray_req(req_b), .gray_addr(ga_b),
    .gray_data(gd_b), .lbp_valid(lv_b), .lbp_addr(la_b), .lbp_data(ld_b),
    .finish(fin_b), .dbg_state(st_b));

  lbp_stream_engine #(.IMG_W(5), .IMG_H(5), .DW(8), .BORDER(0), .CMP_GE(0)) dut_c (
    .clk(clk), .reset(reset), .gray_ready(rdy_c), .gray_req(req_c), .gray_addr(ga_c),
    .gray_data(gd_c), .lbp_valid(lv_c), .lbp_addr(la_c), .lbp_data(ld_c),
    .finish(fin_c), .dbg_state(st_c));

  // Scoreboard state: entries are {addr[15:0], code[7:0]}.
  logic [23:0] exp_q[$];
  logic [23:0] act_q[$];
  int wr_cyc[$];
  int rise_cyc[$];
  int fin_cyc[$];
  int mimg [64];
  int cyc = 0;
  int req_cnt = 0;
  int fin_cnt = 0;
  int fin_addr = 0;
  bit fin_valid = 0;
  bit rq_prev = 0;
  int mon_sel = 0;
  int n_tests = 0;
  int n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Write/finish/request monitor for the selected instance.
  always @(negedge clk) begin
    logic        v, f, rq;
    logic [15:0] ad;
    logic [7:0]  d;
    case (mon_sel)
      0:       begin v = lv_a; f = fin_a; rq = req_a; ad = 16'(la_a); d = ld_a; end
      1:       begin v = lv_b; f = fin_b; rq = req_b; ad = 16'(la_b); d = ld_b; end
      default: begin v = lv_c; f = fin_c; rq = req_c; ad = 16'(la_c); d = ld_c; end
    endcase
    if (v) begin
      act_q.push_back({ad, d});
      wr_cyc.push_back(cyc);
    end
    if (f) begin
      fin_cnt++;
      fin_addr = int'(ad);
      fin_valid = v;
      fin_cyc.push_back(cyc);
    end
    if (rq) req_cnt++;
    if (rq && !rq_prev) rise_cyc.push_back(cyc);
    rq_prev = rq;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [23:0] act_at(input int i);
    if (i < 0 || i >= act_q.size()) return 24'hxxxxxx;
    return act_q[i];
  endfunction

  task automatic clear_mon();
    act_q.delete();
    wr_cyc.delete();
    rise_cyc.delete();
    fin_cyc.delete();
    req_cnt = 0;
    fin_cnt = 0;
    fin_addr = 0;
    fin_valid = 0;
    rq_prev = 0;
  endtask

  // Reference: walk every centre of the image in raster order.
  task automatic build_exp(input int w, input int h, input int border, input int ge);
    int dr[8];
    int dc[8];
    dr = '{-1, -1, -1, 0, 0, 1, 1, 1};
    dc = '{-1, 0, 1, -1, 1, -1, 0, 1};
    exp_q.delete();
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        int addr;
        addr = r*w + c;
        if (r == 0 || r == h-1 || c == 0 || c == w-1) begin
          if (border != 0) exp_q.push_back({16'(addr), 8'h00});
        end else begin
          logic [7:0] code;
          int cen;
          cen = mimg[addr];
          code = 8'h00;
          for (int b = 0; b < 8; b++) begin
            int n;
            n = mimg[(r+dr[b])*w + c + dc[b]];
            code[b] = (ge != 0) ? (n >= cen) : (n > cen);
          end
          exp_q.push_back({16'(addr), code});
        end
      end
    end
  endtask

  task automatic cmp_queues(input string tag);
    int n;
    chk({tag, "_count"}, 32'(act_q.size()), 32'(exp_q.size()));
    n = (act_q.size() < exp_q.size()) ? act_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      chk($sformatf("%s_w%0d", tag, i), 32'(act_q[i]), 32'(exp_q[i]));
  endtask

  task automatic start_frame(input int sel);
    @(negedge clk);
    case (sel)
      0:       rdy_a = 1'b1;
      1:       rdy_b = 1'b1;
      default: rdy_c = 1'b1;
    endcase
    @(negedge clk);
    rdy_a = 1'b0;
    rdy_b = 1'b0;
    rdy_c = 1'b0;
  endtask

  task automatic wait_fin(input int target, input string tag);
    int n;
    n = 0;
    while (fin_cnt < target && n < 3000) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk({tag, "_finish_seen"}, 32'(fin_cnt >= target), 32'd1);
  endtask

  task automatic run_frame(input int sel, input string tag);
    clear_mon();
    start_frame(sel);
    wait_fin(1, tag);
    repeat (3) @(negedge clk);
    #1;
  endtask

  task automatic load_a();
    for (int i = 0; i < 48; i++) mimg[i] = int'(img_a[i]);
  endtask
  task automatic load_b();
    for (int i = 0; i < 16; i++) mimg[i] = int'(img_b[i]);
  endtask
  task automatic load_c();
    for (int i = 0; i < 25; i++) mimg[i] = int'(img_c[i]);
  endtask

  initial begin
    int n;
    reset = 1'b0;
    rdy_a = 1'b0;
    rdy_b = 1'b0;
    rdy_c = 1'b0;
    for (int i = 0; i < 48; i++) img_a[i] = 8'd0;
    for (int i = 0; i < 16; i++) img_b[i] = 8'd0;
    for (int i = 0; i < 25; i++) img_c[i] = 8'd0;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_gray_req", 32'(req_a), 32'd0);
    chk("rst_gray_addr", 32'(ga_a), 32'd0);
    chk("rst_lbp_valid", 32'(lv_a), 32'd0);
    chk("rst_lbp_addr", 32'(la_a), 32'd0);
    chk("rst_lbp_data", 32'(ld_a), 32'd0);
    chk("rst_finish", 32'(fin_a), 32'd0);
    chk("rst_state", 32'(st_a), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Ramp image 8x6: every interior code is F0
    mon_sel = 0;
    for (int i = 0; i < 48; i++) img_a[i] = 8'(i);
    load_a();
    build_exp(8, 6, 0, 1);
    run_frame(0, "ramp");
    cmp_queues("ramp");
    chk("ramp_first_addr", 32'(act_at(0) >> 8), 32'd9);
    chk("ramp_last_addr", 32'(act_at(act_q.size()-1) >> 8), 32'd38);
    chk("ramp_code_f0", 32'(act_at(10) & 24'hff), 32'hf0);
    chk("ramp_fin_addr", 32'(fin_addr), 32'd38);
    chk("ramp_fin_with_valid", 32'(fin_valid), 32'd1);
    chk("ramp_req_cycles", 32'(req_cnt), 32'd48);

    // 4x4 border-zero mode, random pixels
    mon_sel = 1;
    for (int i = 0; i < 16; i++) img_b[i] = 8'($urandom_range(0, 255));
    load_b();
    build_exp(4, 4, 1, 1);
    run_frame(1, "zero");
    cmp_queues("zero");
    chk("zero_req_cycles", 32'(req_cnt), 32'd16);
    chk("zero_consecutive", 32'(wr_cyc.size() == 16 ? wr_cyc[15] - wr_cyc[0] : -1), 32'd15);
    chk("zero_fin_addr", 32'(fin_addr), 32'd15);
    chk("zero_fin_with_valid", 32'(fin_valid), 32'd1);

    // 5x5 strict compare, single bright pixel
    mon_sel = 2;
    for (int i = 0; i < 25; i++) img_c[i] = 8'd10;
    img_c[12] = 8'd200;
    load_c();
    build_exp(5, 5, 0, 0);
    run_frame(2, "spot");
    cmp_queues("spot");
    chk("spot_addr6", 32'(act_at(0)), 32'h000680);
    chk("spot_addr7", 32'(act_at(1)), 32'h000740);
    chk("spot_addr12", 32'(act_at(4)), 32'h000c00);
    chk("spot_addr18", 32'(act_at(8)), 32'h001201);

    // Random frames with many ties between neighbours and centre
    for (int t = 0; t < 3; t++) begin
      mon_sel = 0;
      for (int i = 0; i < 48; i++) img_a[i] = 8'($urandom_range(0, 3));
      load_a();
      build_exp(8, 6, 0, 1);
      run_frame(0, $sformatf("rnd_a%0d", t));
      cmp_queues($sformatf("rnd_a%0d", t));
      mon_sel = 1;
      for (int i = 0; i < 16; i++) img_b[i] = 8'($urandom_range(0, 3));
      load_b();
      build_exp(4, 4, 1, 1);
      run_frame(1, $sformatf("rnd_b%0d", t));
      cmp_queues($sformatf("rnd_b%0d", t));
      mon_sel = 2;
      for (int i = 0; i < 25; i++) img_c[i] = 8'($urandom_range(0, 3));
      load_c();
      build_exp(5, 5, 0, 0);
      run_frame(2, $sformatf("rnd_c%0d", t));
      cmp_queues($sformatf("rnd_c%0d", t));
    end

    // Reset in the middle of a frame
    mon_sel = 0;
    for (int i = 0; i < 48; i++) img_a[i] = 8'(i);
    load_a();
    build_exp(8, 6, 0, 1);
    clear_mon();
    start_frame(0);
    n = 0;
    while (!(req_a === 1'b1 && ga_a === 6'd40) && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("abort_reached_k40", 32'(ga_a), 32'd40);
    reset = 1'b0;
    #1;
    chk("abort_gray_req", 32'(req_a), 32'd0);
    chk("abort_gray_addr", 32'(ga_a), 32'd0);
    chk("abort_lbp_valid", 32'(lv_a), 32'd0);
    chk("abort_lbp_addr", 32'(la_a), 32'd0);
    chk("abort_lbp_data", 32'(ld_a), 32'd0);
    chk("abort_finish", 32'(fin_a), 32'd0);
    clear_mon();
    repeat (4) @(negedge clk);
    #1;
    chk("abort_no_writes", 32'(act_q.size()), 32'd0);
    chk("abort_no_finish", 32'(fin_cnt), 32'd0);
    chk("abort_no_req", 32'(req_cnt), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    run_frame(0, "rerun");
    cmp_queues("rerun");

    // Back-to-back frames with gray_ready held high
    clear_mon();
    n = exp_q.size();
    for (int i = 0; i < n; i++) exp_q.push_back(exp_q[i]);
    @(negedge clk);
    rdy_a = 1'b1;
    wait_fin(1, "b2b_first");
    n = 0;
    while (rise_cyc.size() < 2 && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    rdy_a = 1'b0;
    chk("b2b_second_start", 32'(rise_cyc.size()), 32'd2);
    wait_fin(2, "b2b_second");
    repeat (3) @(negedge clk);
    #1;
    cmp_queues("b2b");
    chk("b2b_restart_gap",
        32'((rise_cyc.size() >= 2 && fin_cyc.size() >= 1) ? rise_cyc[1] - fin_cyc[0] : -1),
        32'd2);
    chk("b2b_fin_count", 32'(fin_cnt), 32'd2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
